// File: rtl/deconv_pkg.sv
// rtl/deconv_pkg.sv - shared sizing and state encoding for the deconvolution result streamer
package deconv_pkg;

  localparam int N          = 2;
  localparam int K          = 3;
  localparam int PIXEL_BITS = 8;
  localparam int NK         = N * K;
  localparam int ADDR_W     = $clog2(NK * NK);
  localparam int DIM_W      = $clog2(NK) + 1;
  localparam int ACC_W      = PIXEL_BITS * 4;
  localparam int SH_W       = $clog2(ACC_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/requant_sat.sv
// rtl/requant_sat.sv - logical right shift of an accumulator with unsigned saturation to pixel width
module requant_sat #(
  parameter int ACC_W = 32,
  parameter int PIX_W = 8,
  parameter int SH_W  = 5
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [SH_W-1:0]  i_shift,
  output logic [PIX_W-1:0] o_pix
);

  logic [ACC_W-1:0] w_shifted;

  assign w_shifted = i_acc >> i_shift;
  assign o_pix     = (|w_shifted[ACC_W-1:PIX_W]) ? {PIX_W{1'b1}} : w_shifted[PIX_W-1:0];

endmodule

// File: rtl/deconv_result_streamer.sv
// rtl/deconv_result_streamer.sv - sweeps the engine result memory and streams requantised pixels
module deconv_result_streamer
  import deconv_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_conv_done,
  input  logic [DIM_W-1:0]      i_out_width,
  input  logic [SH_W-1:0]       i_shift,
  output logic [ADDR_W-1:0]     o_result_address,
  input  logic [ACC_W-1:0]      i_final_output,
  output logic [PIXEL_BITS-1:0] o_m_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic                  o_m_last,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  state_t                r_state;
  state_t                w_next_state;
  logic [DIM_W-1:0]      r_row;
  logic [DIM_W-1:0]      r_col;
  logic [DIM_W-1:0]      r_w;
  logic [SH_W-1:0]       r_shift;
  logic [PIXEL_BITS-1:0] r_m_data;
  logic                  r_m_valid;
  logic                  r_m_last;
  logic                  r_busy;

  logic [DIM_W-1:0]      w_width_clamped;
  logic [DIM_W-1:0]      w_w_last;
  logic                  w_at_end;
  logic                  w_load;
  logic                  w_accept;
  logic                  w_frame_done;
  logic [PIXEL_BITS-1:0] w_pix;

  assign w_width_clamped = (i_out_width > DIM_W'(NK)) ? DIM_W'(NK) : i_out_width;
  assign w_w_last        = r_w - DIM_W'(1);
  assign w_at_end        = (r_row == w_w_last) && (r_col == w_w_last);
  assign w_load          = (r_state == STREAM) && (!r_m_valid || i_m_ready);
  assign w_accept        = r_m_valid && i_m_ready;

  assign o_result_address = ADDR_W'(r_row) * ADDR_W'(NK) + ADDR_W'(r_col);
  assign o_m_data         = r_m_data;
  assign o_m_valid        = r_m_valid;
  assign o_m_last         = r_m_last;
  assign o_busy           = r_busy;
  assign o_frame_done     = w_frame_done;

  requant_sat #(
    .ACC_W (ACC_W),
    .PIX_W (PIXEL_BITS),
    .SH_W  (SH_W)
  ) u_requant (
    .i_acc   (i_final_output),
    .i_shift (r_shift),
    .o_pix   (w_pix)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_conv_done) begin
          w_next_state = (w_width_clamped == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (w_load && w_at_end) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (w_accept) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_frame_done = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Counters stay on the final pixel after its load so the address never leaves the window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row     <= '0;
      r_col     <= '0;
      r_w       <= '0;
      r_shift   <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      if (r_state == IDLE && i_conv_done) begin
        r_w     <= w_width_clamped;
        r_shift <= i_shift;
        r_row   <= '0;
        r_col   <= '0;
        r_busy  <= (w_width_clamped != '0);
      end
      if (w_load) begin
        r_m_data  <= w_pix;
        r_m_valid <= 1'b1;
        r_m_last  <= w_at_end;
        if (!w_at_end) begin
          if (r_col == w_w_last) begin
            r_col <= '0;
            r_row <= r_row + DIM_W'(1);
          end else begin
            r_col <= r_col + DIM_W'(1);
          end
        end
      end
      if (r_state == DRAIN && w_accept) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
        r_busy    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/deconv_result_streamer.md
Name: deconv_result_streamer

Overview:
- Downstream stage of the 2D transposed-convolution engine.
- After the engine pulses done, this block sweeps the engine's result memory through its address/data read port. Sweep is row-major over an out_width x out_width window of the N*K x N*K result grid.
- Each 32-bit accumulator is requantised to pixel_bits by right shift and unsigned saturation. Pixels are emitted on a valid/ready stream with an end-of-frame marker.
- Holds busy so the controller does not re-enable the engine, which clears its result memory, mid-readout.

Parameters:
- N, 2, input feature map side length (must match engine).
- K, 3, maximum kernel side length (must match engine).
- pixel_bits, 8, output pixel width; accumulator width is pixel_bits*4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- conv_done  in  1  one-cycle done pulse from the engine; starts a frame.
- out_width  in  $clog2(N*K)+1  output side length; sampled with conv_done.
- shift  in  $clog2(pixel_bits*4)  requant right-shift amount; sampled with conv_done.
- result_address  out  $clog2(N*K*N*K)  engine result memory read address.
- final_output  in  pixel_bits*4  engine read data; combinational from result_address, zero latency.
- m_data  out  pixel_bits  requantised output pixel.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts when m_valid && m_ready.
- m_last  out  1  marks the final pixel of the frame; qualified by m_valid.
- busy  out  1  high from frame start until the last beat is accepted.
- frame_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (async, rst_n low): state IDLE; m_valid, m_last, busy, frame_done, m_data, result_address, row and col counters all 0. Reset mid-frame abandons the frame; nothing is resumed.
- Counters: row and col, each $clog2(N*K)+1 bits. result_address = row*(N*K)+col, registered-counter driven, so final_output is valid in the same cycle.
- Width latch: w = out_width clamped to N*K if out_width > N*K. out_width==0 means an empty frame.
- Requant: v = final_output >> shift (logical). m_data = (v > 2^pixel_bits-1) ? 2^pixel_bits-1 : v[pixel_bits-1:0].
- Load condition: load = (state==STREAM) && (!m_valid || m_ready). On load:
  - m_data <= requant(final_output);
  - m_valid <= 1;
  - m_last <= (row==w-1 && col==w-1);
  - col advances, wrapping to 0 at w-1 with row incrementing.
- Holding rule: when m_valid && !m_ready, m_data, m_last and the address are held stable.
- States:
  - IDLE: busy=0. On conv_done: latch w and shift, zero row/col. If w==0, go to DONE; else go to STREAM and set busy=1.
  - STREAM: on a load where m_last is being set, go to DRAIN. Otherwise stay.
  - DRAIN: when m_valid && m_ready, clear m_valid and m_last, go to DONE.
  - DONE: frame_done=1 for exactly one cycle, busy<=0, go to IDLE.
- Latency: conv_done sampled at edge E, first m_valid high after edge E+1. With m_ready held high, one beat per cycle, w*w beats total. frame_done is asserted the cycle after the last accepting edge.
- conv_done outside IDLE is ignored; the running frame is unaffected.
- m_valid never drops without acceptance. m_valid is 0 in IDLE and DONE.

Decomposition:
- Shared package deconv_pkg:
  - localparams NK=N*K, ADDR_W=$clog2(NK*NK), DIM_W=$clog2(NK)+1, ACC_W=pixel_bits*4;
  - state encodings IDLE/STREAM/DRAIN/DONE.
- One combinational sub-module, requant_sat: ACC_W input plus shift in, pixel_bits saturated output. Reusable by other output stages.

Test Plan:
- Bench RAM model final_output = addr*10. N=2, K=3, out_width=4, shift=0, m_ready=1 -> 16 beats, addresses 0,1,2,3,6,7,8,9,12..21. m_data 0,10,20,30,60,...,210. m_last only on beat 16 (addr 21). frame_done one cycle later.
- out_width=6, shift=0 -> 36 beats. addr 26 gives 255 (260 saturated), addr 25 gives 250. shift=2 rerun -> addr 26 gives 65, addr 35 gives 87.
- Backpressure: m_ready toggled 1,0,0,1 repeating, out_width=3 -> 9 beats in order 0,10,20,60,70,80,120,130,140. m_data and result_address stable while stalled. busy high throughout.
- out_width=0 -> no m_valid, frame_done pulses 2 edges after conv_done. out_width=7 -> clamped to 36 beats.
- Second conv_done mid-frame (beat 5 of 16) -> ignored, frame completes with 16 beats unchanged.
- rst_n low at beat 7 -> m_valid, busy, m_last, result_address drop to 0 immediately (async). Fresh conv_done after release -> full frame restarts from addr 0.
